// File: rtl/lif_tdm_scheduler_if.sv
// Bus bundle for the LIF timestep scheduler: tick request, input currents,
// configuration write port, membrane monitor and step status.
interface lif_tdm_scheduler_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic              tick;
    logic [N*W-1:0]    cur_in;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [7:0]        cfg_data;
    logic [SW-1:0]     mon_sel;
    logic [W-1:0]      mem_mon;
    logic [N-1:0]      spike;
    logic              done;
    logic              busy;
    logic              overrun;

    // Driver side (pin decoder / testbench).
    modport master (
        output tick, cur_in, cfg_we, cfg_addr, cfg_data, mon_sel,
        input  mem_mon, spike, done, busy, overrun
    );

    // Scheduler side.
    modport slave (
        input  tick, cur_in, cfg_we, cfg_addr, cfg_data, mon_sel,
        output mem_mon, spike, done, busy, overrun
    );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF neuron scheduler: one shared leak/integrate/fire
// datapath walks N neurons per tick (FETCH/UPDATE per neuron), then
// publishes the spike vector with a one-cycle done pulse.
module lif_tdm_scheduler #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lif_tdm_scheduler_if.slave    bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    // Threshold is an 8-bit register; compare in the wider of the two widths.
    localparam int TW = (W > 8) ? W : 8;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  idx_q, idx_d;

    // Live configuration registers and their per-step snapshots.
    logic [7:0]     thr_q, thr_s_q;
    logic [2:0]     leak_q, leak_s_q;
    logic [3:0]     refr_q, refr_s_q;

    // Per-neuron state, gathered from the generate blocks below.
    logic [W-1:0]   v_all   [N];
    logic [3:0]     r_all   [N];
    logic [W-1:0]   cur_all [N];
    logic [N-1:0]   acc_all;

    // Shared datapath operand registers, loaded in FETCH.
    logic [W-1:0]   dp_v_q, dp_i_q;
    logic [3:0]     dp_r_q;

    logic [N-1:0]   spike_q;
    logic           overrun_q;
    logic [W-1:0]   mem_mon_q;

    logic           busy_c, done_c;
    logic           idle_or_done, tick_accept, tick_drop;
    logic           ctrl_we, clear_all, ovr_clr;
    logic           last_neuron;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign tick_accept  = bus.tick && idle_or_done;
    assign tick_drop    = bus.tick && !idle_or_done;
    assign ctrl_we      = bus.cfg_we && (bus.cfg_addr == 2'd3);
    assign clear_all    = ctrl_we && bus.cfg_data[1] && idle_or_done;
    assign ovr_clr      = ctrl_we && bus.cfg_data[0];
    assign last_neuron  = (idx_q == SW'(N - 1));

    // FSM state register and neuron index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next-state: walk FETCH/UPDATE pairs for every neuron, then DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.tick) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_UPDATE;
            S_UPDATE: begin
                if (last_neuron) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    idx_d   = idx_q + SW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy through the neuron walk, done for the DONE cycle.
    always_comb begin
        busy_c = (state_q == S_FETCH) || (state_q == S_UPDATE);
        done_c = (state_q == S_DONE);
    end

    // Configuration registers; snapshot taken when a tick is accepted so a
    // write in the same cycle only affects the following step.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q    <= 8'd200;
            leak_q   <= 3'd2;
            refr_q   <= 4'd2;
            thr_s_q  <= 8'd200;
            leak_s_q <= 3'd2;
            refr_s_q <= 4'd2;
        end else begin
            if (tick_accept) begin
                thr_s_q  <= thr_q;
                leak_s_q <= leak_q;
                refr_s_q <= refr_q;
            end
            if (bus.cfg_we) begin
                case (bus.cfg_addr)
                    2'd0:    thr_q  <= bus.cfg_data;
                    2'd1:    leak_q <= bus.cfg_data[2:0];
                    2'd2:    refr_q <= bus.cfg_data[3:0];
                    default: ;
                endcase
            end
        end
    end

    // Leak / integrate / threshold / refractory update for the fetched neuron.
    logic [W:0]     sum;
    logic [W-1:0]   sat;
    logic [W-1:0]   v_new;
    logic [3:0]     r_new;
    logic           fire;

    always_comb begin
        sum   = {1'b0, dp_v_q} - {1'b0, (dp_v_q >> leak_s_q)} + {1'b0, dp_i_q};
        sat   = sum[W] ? {W{1'b1}} : sum[W-1:0];
        fire  = 1'b0;
        v_new = sat;
        r_new = dp_r_q;
        if (dp_r_q != 4'd0) begin
            r_new = dp_r_q - 4'd1;
            v_new = '0;
        end else if (TW'(sat) >= TW'(thr_s_q)) begin
            fire  = 1'b1;
            v_new = '0;
            r_new = refr_s_q;
        end
    end

    // Per-neuron membrane, refractory, current snapshot and spike bit.
    for (genvar gi = 0; gi < N; gi++) begin : g_neuron
        logic [W-1:0] v_q;
        logic [3:0]   r_q;
        logic [W-1:0] cur_q;
        logic         acc_q;
        logic         wr_en;

        assign wr_en = (state_q == S_UPDATE) && (idx_q == SW'(gi));

        // Write back in UPDATE; bulk clear only between steps.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= '0;
                r_q   <= '0;
                cur_q <= '0;
                acc_q <= 1'b0;
            end else begin
                if (clear_all) begin
                    v_q <= '0;
                    r_q <= '0;
                end else if (wr_en) begin
                    v_q   <= v_new;
                    r_q   <= r_new;
                    acc_q <= fire;
                end
                if (tick_accept) begin
                    cur_q <= bus.cur_in[gi*W +: W];
                end
            end
        end

        assign v_all[gi]   = v_q;
        assign r_all[gi]   = r_q;
        assign cur_all[gi] = cur_q;
        assign acc_all[gi] = acc_q;
    end

    // Load the shared datapath operands during FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_v_q <= '0;
            dp_r_q <= '0;
            dp_i_q <= '0;
        end else if (state_q == S_FETCH) begin
            dp_v_q <= v_all[idx_q];
            dp_r_q <= r_all[idx_q];
            dp_i_q <= cur_all[idx_q];
        end
    end

    // Spike vector: the last neuron's bit is merged live as DONE is entered.
    logic [N-1:0] spike_d;
    always_comb begin
        spike_d        = acc_all;
        spike_d[N-1]   = fire;
    end

    // Published spike vector, sticky overrun and membrane monitor.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q   <= '0;
            overrun_q <= 1'b0;
            mem_mon_q <= '0;
        end else begin
            if ((state_q == S_UPDATE) && last_neuron) begin
                spike_q <= spike_d;
            end
            if (tick_drop) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
            mem_mon_q <= v_all[bus.mon_sel];
        end
    end

    assign bus.spike   = spike_q;
    assign bus.overrun = overrun_q;
    assign bus.mem_mon = mem_mon_q;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler (N=4, W=8): a vector table of
// config writes / steps with expected spikes and membranes, followed by
// hand sequences for overrun, mid-step config write and mid-step reset.
module tb_lif_tdm_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lif_tdm_scheduler_if #(.N(N), .W(W)) bus ();

    lif_tdm_scheduler #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         we;
        logic [1:0]   addr;
        logic [7:0]   data;
        logic         step;
        logic [31:0]  cur;
        logic [3:0]   exp_spike;
        logic [31:0]  exp_v;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        next_cycle();
        bus.cfg_we   = 1'b0;
    endtask

    // Current cycle becomes cycle 0 of a step.
    task automatic start_tick(input logic [31:0] cur);
        bus.cur_in = cur;
        bus.tick   = 1'b1;
    endtask

    // Walks cycles 1..2N+1 of a step, checking busy/done timing and spikes.
    // Optionally issues a config write in cycle wr_cyc and a new tick in DONE.
    task automatic finish_step(input logic [3:0] exp_spike, input bit tick_at_done,
                               input int wr_cyc, input logic [1:0] wa, input logic [7:0] wd);
        for (int c = 1; c <= 2*N+1; c++) begin
            next_cycle();
            bus.tick   = 1'b0;
            bus.cfg_we = 1'b0;
            if (c == wr_cyc) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = wa;
                bus.cfg_data = wd;
            end
            if (c <= 2*N) begin
                check($sformatf("busy_c%0d", c), bus.busy, 1);
                check($sformatf("done_c%0d", c), bus.done, 0);
            end else begin
                check("done_pulse", bus.done, 1);
                check("busy_in_done", bus.busy, 0);
                check("spike", bus.spike, exp_spike);
                $display("step done: spike=%b overrun=%0d", bus.spike, bus.overrun);
                if (tick_at_done) bus.tick = 1'b1;
            end
        end
    endtask

    task automatic check_mem(input logic [31:0] exp_v);
        for (int k = 0; k < N; k++) begin
            bus.mon_sel = 2'(k);
            next_cycle();
            check($sformatf("mem_mon%0d", k), bus.mem_mon, exp_v[k*W +: W]);
        end
    endtask

    initial begin
        int dones;
        bit done9;

        bus.tick = 1'b0; bus.cur_in = '0; bus.cfg_we = 1'b0;
        bus.cfg_addr = '0; bus.cfg_data = '0; bus.mon_sel = '0;

        //            we    addr  data   step  cur           spk   exp_v
        tbl[0]  = '{1'b0, 2'd0, 8'd0,   1'b1, 32'h32323232, 4'h0, 32'h32323232};
        tbl[1]  = '{1'b1, 2'd3, 8'd2,   1'b0, 32'h0,        4'h0, 32'h0};
        tbl[2]  = '{1'b0, 2'd0, 8'd0,   1'b1, 32'h00000064, 4'h0, 32'h00000064};
        tbl[3]  = '{1'b0, 2'd0, 8'd0,   1'b1, 32'h00000064, 4'h0, 32'h000000AF};
        tbl[4]  = '{1'b0, 2'd0, 8'd0,   1'b1, 32'h00000064, 4'h1, 32'h00000000};
        tbl[5]  = '{1'b0, 2'd0, 8'd0,   1'b1, 32'h00000064, 4'h0, 32'h00000000};
        tbl[6]  = '{1'b0, 2'd0, 8'd0,   1'b1, 32'h00000064, 4'h0, 32'h00000000};
        tbl[7]  = '{1'b0, 2'd0, 8'd0,   1'b1, 32'h00000064, 4'h0, 32'h00000064};
        tbl[8]  = '{1'b1, 2'd3, 8'd2,   1'b0, 32'h0,        4'h0, 32'h0};
        tbl[9]  = '{1'b1, 2'd1, 8'd7,   1'b0, 32'h0,        4'h0, 32'h0};
        tbl[10] = '{1'b1, 2'd0, 8'd255, 1'b0, 32'h0,        4'h0, 32'h0};
        tbl[11] = '{1'b0, 2'd0, 8'd0,   1'b1, 32'hC8C8C8C8, 4'h0, 32'hC8C8C8C8};
        tbl[12] = '{1'b0, 2'd0, 8'd0,   1'b1, 32'hC8C8C8C8, 4'hF, 32'h00000000};
        tbl[13] = '{1'b1, 2'd1, 8'd2,   1'b0, 32'h0,        4'h0, 32'h0};
        tbl[14] = '{1'b1, 2'd0, 8'd200, 1'b0, 32'h0,        4'h0, 32'h0};

        // Reset for two cycles; all outputs must be zero.
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        check("rst_spike", bus.spike, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_mem_mon", bus.mem_mon, 0);

        // Table-driven steps (defaults thr=200 leak=2 refr=2 seen in 2..7).
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].we) cfg_write(tbl[i].addr, tbl[i].data);
            if (tbl[i].step) begin
                $display("vector %0d: cur=%h", i, tbl[i].cur);
                start_tick(tbl[i].cur);
                finish_step(tbl[i].exp_spike, 1'b0, 0, 2'd0, 8'd0);
                check_mem(tbl[i].exp_v);
            end
        end

        // Overrun: tick in cycle 0 and again in cycle 4.
        cfg_write(2'd3, 8'd2);
        start_tick(32'h0);
        dones = 0;
        done9 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            bus.tick = (c == 4);
            if (bus.done) begin
                dones++;
                if (c == 9) done9 = 1'b1;
            end
            if (c == 6) check("overrun_set", bus.overrun, 1);
        end
        check("overrun_done_count", dones, 1);
        check("overrun_done_at9", done9, 1);
        check("overrun_held", bus.overrun, 1);
        $display("overrun sequence: dones=%0d overrun=%0d", dones, bus.overrun);
        cfg_write(2'd3, 8'd1);
        check("overrun_clear", bus.overrun, 0);

        // Back-to-back: tick in the DONE cycle is accepted without overrun.
        start_tick(32'h0);
        finish_step(4'h0, 1'b1, 0, 2'd0, 8'd0);
        finish_step(4'h0, 1'b0, 0, 2'd0, 8'd0);
        check("b2b_no_overrun", bus.overrun, 0);

        // Mid-step threshold write only affects the next step.
        cfg_write(2'd3, 8'd2);
        start_tick(32'h64646464);
        finish_step(4'h0, 1'b0, 3, 2'd0, 8'd60);
        check_mem(32'h64646464);
        start_tick(32'h64646464);
        finish_step(4'hF, 1'b0, 0, 2'd0, 8'd0);
        check_mem(32'h00000000);
        cfg_write(2'd0, 8'd200);

        // Same-cycle tick and threshold write: step uses old thr=200.
        start_tick(32'h64646464);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 8'd60;
        finish_step(4'h0, 1'b0, 0, 2'd0, 8'd0);
        cfg_write(2'd0, 8'd200);

        // Mid-step reset: V built up, then rst in cycle 5.
        cfg_write(2'd3, 8'd2);
        start_tick(32'h32323232);
        finish_step(4'h0, 1'b0, 0, 2'd0, 8'd0);
        start_tick(32'h32323232);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            bus.tick = 1'b0;
        end
        rst = 1'b1;
        next_cycle();
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        rst = 1'b0;
        dones = 0;
        for (int c = 7; c <= 12; c++) begin
            next_cycle();
            if (bus.done) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_spike", bus.spike, 0);
        $display("mid-step reset sequence complete");
        check_mem(32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
